// File: rtl/paddle_engine.sv
// Paddle position engine: accepts move requests, waits a settle delay, then commits the new
// top row at the next frame start so the paddle never moves mid-frame; also renders its pixel.
module paddle_engine #(
  parameter int unsigned Y_INIT      = 195,
  parameter int unsigned X_BAR       = 10,
  parameter int unsigned BAR_W       = 10,
  parameter int unsigned BAR_H       = 90,
  parameter int unsigned Y_MIN       = 6,
  parameter int unsigned Y_MAX       = 472,
  parameter int unsigned HOLD_CYCLES = 1048575
) (
  input  logic       clk_in,
  input  logic       i_rst,
  input  logic       enable,
  input  logic       cmd_valid,
  input  logic       cmd_dir,
  input  logic [8:0] cmd_step,
  output logic       cmd_ready,
  input  logic       frame_start,
  input  logic       o_active,
  input  logic [9:0] o_x,
  input  logic [8:0] o_y,
  output logic [8:0] y_pos,
  output logic       busy,
  output logic       color
);

  localparam int unsigned CntW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CntW-1:0] HoldLast = CntW'((HOLD_CYCLES == 0) ? 0 : HOLD_CYCLES - 1);
  localparam logic [10:0] YLow  = 11'(Y_MIN);
  localparam logic [10:0] YHigh = 11'(Y_MAX - BAR_H + 1);
  localparam logic [10:0] XLo   = 11'(X_BAR);
  localparam logic [10:0] XHi   = 11'(X_BAR + BAR_W - 1);
  localparam logic [10:0] BarH1 = 11'(BAR_H - 1);

  typedef enum logic [1:0] {StIdle, StHold, StArmed} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [8:0]      target_q, target_d;
  logic [8:0]      y_pos_q, y_pos_d;
  logic            color_q, color_d;

  logic [10:0] y_ext, step_ext, down_sum, target_calc;
  logic [10:0] ox_ext, oy_ext;
  logic        cmd_accept;

  assign cmd_ready  = enable && (state_q == StIdle) && !i_rst;
  assign cmd_accept = cmd_valid && cmd_ready;

  // 11-bit arithmetic so neither the sum nor the up-move bound can wrap.
  always_comb begin
    y_ext    = {2'b00, y_pos_q};
    step_ext = {2'b00, cmd_step};
    down_sum = y_ext + step_ext;
    if (cmd_dir) begin
      target_calc = (down_sum > YHigh) ? YHigh : down_sum;
    end else begin
      target_calc = ((step_ext + YLow) > y_ext) ? YLow : (y_ext - step_ext);
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    y_pos_d  = y_pos_q;
    if (!enable) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_accept) begin
            target_d = target_calc[8:0];
            cnt_d    = '0;
            state_d  = StHold;
          end
        end
        StHold: begin
          cnt_d = cnt_q + CntW'(1);
          if ((HOLD_CYCLES == 0) || (cnt_q == HoldLast)) begin
            state_d = StArmed;
          end
        end
        StArmed: begin
          if (frame_start) begin
            y_pos_d = target_q;
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    ox_ext  = {1'b0, o_x};
    oy_ext  = {2'b00, o_y};
    color_d = enable && o_active &&
              (ox_ext >= XLo) && (ox_ext <= XHi) &&
              (oy_ext >= y_ext) && (oy_ext <= (y_ext + BarH1));
  end

  always_ff @(posedge clk_in) begin
    if (i_rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      target_q <= 9'(Y_INIT);
      y_pos_q  <= 9'(Y_INIT);
      color_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      y_pos_q  <= y_pos_d;
      color_q  <= color_d;
    end
  end

  assign y_pos = y_pos_q;
  assign busy  = (state_q != StIdle);
  assign color = color_q;

endmodule

// File: doc/paddle_engine.md
PADDLE_ENGINE -- requirements
Module: paddle_engine

Interface
REQ-001 SHALL have parameter Y_INIT, default 195: paddle top row after reset.
REQ-002 SHALL have parameter X_BAR, default 10: paddle left column.
REQ-003 SHALL have parameter BAR_W, default 10: paddle width in pixels.
REQ-004 SHALL have parameter BAR_H, default 90: paddle height in pixels.
REQ-005 SHALL have parameter Y_MIN, default 6: lowest legal top row.
REQ-006 SHALL have parameter Y_MAX, default 472: highest legal bottom row.
REQ-007 SHALL have parameter HOLD_CYCLES, default 1048575: settle delay before a move is armed.
REQ-008 SHALL have port clk_in, input, 1 bit: the single clock.
REQ-009 SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-010 SHALL have port enable, input, 1 bit: block enable.
REQ-011 SHALL have port cmd_valid, input, 1 bit: a move request is present.
REQ-012 SHALL have port cmd_dir, input, 1 bit: 1 moves down (increasing y), 0 moves up.
REQ-013 SHALL have port cmd_step, input, 9 bits: move magnitude in pixels.
REQ-014 SHALL have port cmd_ready, output, 1 bit: high when a request can be accepted.
REQ-015 SHALL have port frame_start, input, 1 bit: one-cycle pulse at the start of vertical blank.
REQ-016 SHALL have port o_active, input, 1 bit: high while a visible pixel is being drawn.
REQ-017 SHALL have port o_x, input, 10 bits: current pixel column.
REQ-018 SHALL have port o_y, input, 9 bits: current pixel row.
REQ-019 SHALL have port y_pos, output, 9 bits: committed paddle top row.
REQ-020 SHALL have port busy, output, 1 bit: a move is pending.
REQ-021 SHALL have port color, output, 1 bit: registered paddle pixel flag.

Function
REQ-022 SHALL implement states IDLE, HOLD and ARMED; busy SHALL be 1 in HOLD or ARMED; cmd_ready SHALL equal enable AND state==IDLE.
REQ-023 SHALL accept a command on a cycle where cmd_valid and cmd_ready are both high, latch the target row, clear the hold counter and enter HOLD.
REQ-024 SHALL compute the target row with at least 11-bit unsigned arithmetic so that no intermediate result wraps.
REQ-025 SHALL, for a down move, set target = min(y_pos+cmd_step, Y_MAX-BAR_H+1); for an up move, target = Y_MIN if cmd_step > y_pos-Y_MIN, else y_pos-cmd_step.
REQ-026 SHALL treat cmd_step=0 as a legal move: target = y_pos, full sequence still executes.
REQ-027 SHALL, in HOLD, increment the hold counter each cycle and go to ARMED on the cycle the counter equals HOLD_CYCLES-1; HOLD_CYCLES=0 SHALL go to ARMED on the next cycle.
REQ-028 SHALL, in ARMED, wait for frame_start; on the cycle frame_start=1 it SHALL write target into y_pos (visible the next cycle) and return to IDLE.
REQ-029 SHALL keep y_pos constant outside the commit cycle, so the paddle never changes mid-frame.
REQ-030 SHALL ignore cmd_valid while busy: no queueing, no target change.
REQ-031 SHALL, when enable=0 in any state, go to IDLE on the next cycle, discard any pending target and keep y_pos unchanged.
REQ-032 SHALL register color one cycle after the inputs: color = enable AND o_active AND X_BAR<=o_x<=X_BAR+BAR_W-1 AND y_pos<=o_y<=y_pos+BAR_H-1, evaluated on the prior cycle's inputs.
REQ-033 SHALL drive color=0 whenever the prior cycle had o_active=0 or enable=0, with no held values and no latches.

Reset
REQ-034 SHALL, on a clk_in edge with i_rst=1, set y_pos=Y_INIT, state=IDLE, hold counter=0, color=0 and busy=0.
REQ-035 SHALL let i_rst override every other input, including a pending commit or a simultaneous frame_start.
REQ-036 SHALL, during reset, drive cmd_ready low, and SHALL drive it to enable from the first cycle after reset.

Verification (HOLD_CYCLES=4)
REQ-037 SHALL test: a down move of 20 from 195, with frame_start 10 cycles later -> busy for the whole interval; y_pos=215 the cycle after frame_start; a frame_start during HOLD has no effect.
REQ-038 SHALL test: a down move of 300 from 195 -> y_pos=383 (clamped to Y_MAX-BAR_H+1); an up move of 500 -> y_pos=6.
REQ-039 SHALL test: a second cmd_valid while busy -> cmd_ready=0; after commit, y_pos reflects only the first move.
REQ-040 SHALL test: enable dropped in ARMED -> IDLE; the following frame_start leaves y_pos unchanged; cmd_ready=1 after enable returns.
REQ-041 SHALL test: a raster sweep with y_pos=195 -> color=1 exactly for x 10..19 and y 195..284, one cycle late; color=0 whenever o_active=0.
REQ-042 SHALL test: i_rst asserted in HOLD together with frame_start -> y_pos=195, busy=0, color=0 on the next cycle.
